// File: rtl/mmio_rd_pkg.sv
// Shared types and default widths for the MMIO multi-cycle read response path.
package mmio_rd_pkg;

    localparam int MMIO_TID_WIDTH  = 9;
    localparam int MMIO_DATA_WIDTH = 64;

    typedef struct packed {
        logic [MMIO_TID_WIDTH-1:0]  tid;
        logic [MMIO_DATA_WIDTH-1:0] data;
    } rd_rsp_t;

    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/fifo_showahead.sv
// Generic show-ahead FIFO: head entry is visible combinationally whenever not empty.
module fifo_showahead #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic             full,
    output logic             dropped
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             pop_en;
    logic             wr_en;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop_en  = pop && !empty;
    // A pop in the same cycle frees the slot the write lands in, so full+pop still accepts.
    assign wr_en   = push && (!full || pop_en);
    assign dropped = push && full && !pop_en;

    assign head_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= push_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_rd_resp_queue.sv
// Buffers read data from the non-stallable delay pipeline and issues read credits
// so every in-flight read is guaranteed a buffer slot.
module mmio_rd_resp_queue
    import mmio_rd_pkg::*;
#(
    parameter int DATA_WIDTH = MMIO_DATA_WIDTH,
    parameter int TID_WIDTH  = MMIO_TID_WIDTH,
    parameter int DEPTH      = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       req_valid,
    output logic                       req_ready,
    input  logic                       in_valid,
    input  logic [TID_WIDTH-1:0]       in_tid,
    input  logic [DATA_WIDTH-1:0]      in_data,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [TID_WIDTH-1:0]       rsp_tid,
    output logic [DATA_WIDTH-1:0]      rsp_data,
    output logic [$clog2(DEPTH+1)-1:0] credits,
    output logic                       overflow_err
);

    localparam int CW = $clog2(DEPTH + 1);

    // Same layout as rd_rsp_t, sized by this instance's parameters.
    typedef struct packed {
        logic [TID_WIDTH-1:0]  tid;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    entry_t          push_entry;
    entry_t          head_entry;
    logic            empty;
    logic            full;
    logic            dropped;
    logic            issue;
    logic            ret;
    logic [CW-1:0]   credits_q;
    logic [CW-1:0]   credits_d;

    assign push_entry = '{tid: in_tid, data: in_data};

    fifo_showahead #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (in_valid),
        .push_data (push_entry),
        .pop       (ret),
        .head_data (head_entry),
        .empty     (empty),
        .full      (full),
        .dropped   (dropped)
    );

    assign rsp_valid = !empty;
    assign rsp_tid   = head_entry.tid;
    assign rsp_data  = head_entry.data;

    assign req_ready = (credits_q != '0);
    assign issue     = req_valid && req_ready;
    assign ret       = rsp_valid && rsp_ready;
    assign credits   = credits_q;

    always_comb begin
        credits_d = credits_q;
        if (issue && !ret) begin
            credits_d = credits_q - CW'(1);
        end else if (ret && !issue) begin
            credits_d = credits_q + CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            credits_q    <= CW'(DEPTH);
            overflow_err <= 1'b0;
        end else begin
            credits_q <= credits_d;
            if (dropped) begin
                overflow_err <= 1'b1;
            end
        end
    end

    a_credit_overflow: assert property (@(posedge clk) disable iff (rst)
        !(ret && !issue && (credits_q == CW'(DEPTH))));

    a_credit_underflow: assert property (@(posedge clk) disable iff (rst)
        !(issue && !ret && (credits_q == '0)));

endmodule

// File: tb/tb_mmio_rd_resp_queue.sv
// Directed bench for mmio_rd_resp_queue with hand-computed expected values.
module tb_mmio_rd_resp_queue;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        in_valid = 1'b0;
    logic [8:0]  in_tid = '0;
    logic [63:0] in_data = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [8:0]  rsp_tid;
    logic [63:0] rsp_data;
    logic [3:0]  credits;
    logic        overflow_err;

    int checks = 0;
    int failures = 0;

    mmio_rd_resp_queue #(.DATA_WIDTH(64), .TID_WIDTH(9), .DEPTH(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .in_valid     (in_valid),
        .in_tid       (in_tid),
        .in_data      (in_data),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_tid      (rsp_tid),
        .rsp_data     (rsp_data),
        .credits      (credits),
        .overflow_err (overflow_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid = 1'b0;
        in_valid  = 1'b0;
        rsp_ready = 1'b0;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic issue_n(input int n);
        req_valid = 1'b1;
        for (int i = 0; i < n; i++) tick();
        req_valid = 1'b0;
    endtask

    task automatic push_tid(input logic [8:0] tid);
        in_valid = 1'b1;
        in_tid   = tid;
        in_data  = 64'hA5A5_0000_0000_0000 | 64'(tid);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tick();
        checks++; if (credits !== 4'd8) begin failures++; $display("FAIL reset_credits got=%0d exp=8", credits); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow_err); end
    endtask

    task automatic test_single();
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        checks++; if (credits !== 4'd7) begin failures++; $display("FAIL single_credits_c1 got=%0d exp=7", credits); end
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_early_valid got=%b exp=0", rsp_valid); end
        in_valid = 1'b1; in_tid = 9'h005; in_data = 64'hDEAD; rsp_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL single_valid_c5 got=%b exp=1", rsp_valid); end
        checks++; if (rsp_tid !== 9'h005) begin failures++; $display("FAIL single_tid got=%0h exp=5", rsp_tid); end
        checks++; if (rsp_data !== 64'hDEAD) begin failures++; $display("FAIL single_data got=%0h exp=dead", rsp_data); end
        checks++; if (credits !== 4'd7) begin failures++; $display("FAIL single_credits_c5 got=%0d exp=7", credits); end
        tick();
        checks++; if (credits !== 4'd8) begin failures++; $display("FAIL single_credits_c6 got=%0d exp=8", credits); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL single_valid_c6 got=%b exp=0", rsp_valid); end
        idle();
    endtask

    task automatic test_fill_drain();
        rsp_ready = 1'b0;
        issue_n(8);
        checks++; if (credits !== 4'd0) begin failures++; $display("FAIL fill_credits got=%0d exp=0", credits); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_req_ready got=%b exp=0", req_ready); end
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_tid = 9'(i); in_data = 64'h1000 + 64'(i);
            tick();
        end
        in_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'(i) || rsp_data !== 64'h1000 + 64'(i)) begin
                failures++; $display("FAIL drain_entry_%0d got=%b/%0h/%0h exp=1/%0h/%0h", i, rsp_valid, rsp_tid, rsp_data, i, 64'h1000 + 64'(i));
            end
            tick();
        end
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL drain_empty got=%b exp=0", rsp_valid); end
        checks++; if (credits !== 4'd8) begin failures++; $display("FAIL drain_credits got=%0d exp=8", credits); end
    endtask

    task automatic test_count_one();
        issue_n(2);
        push_tid(9'h031);
        checks++; if (rsp_tid !== 9'h031) begin failures++; $display("FAIL one_head got=%0h exp=31", rsp_tid); end
        in_valid = 1'b1; in_tid = 9'h032; in_data = 64'h32; rsp_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        checks++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'h032) begin
            failures++; $display("FAIL one_advance got=%b/%0h exp=1/32", rsp_valid, rsp_tid);
        end
        checks++; if (credits !== 4'd7) begin failures++; $display("FAIL one_credits got=%0d exp=7", credits); end
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || credits !== 4'd8) begin
            failures++; $display("FAIL one_final got=%b/%0d exp=0/8", rsp_valid, credits);
        end
    endtask

    task automatic test_full_simul();
        logic [8:0] exp_tids [8];
        exp_tids = '{9'h013, 9'h014, 9'h015, 9'h016, 9'h017, 9'h018, 9'h020, 9'h021};
        issue_n(8);
        for (int i = 0; i < 8; i++) push_tid(9'h011 + 9'(i));
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (credits !== 4'd1 || rsp_tid !== 9'h012) begin
            failures++; $display("FAIL simul_prep got=%0d/%0h exp=1/12", credits, rsp_tid);
        end
        push_tid(9'h020);
        in_valid = 1'b1; in_tid = 9'h021; in_data = 64'h21;
        rsp_ready = 1'b1; req_valid = 1'b1;
        tick();
        idle();
        checks++; if (credits !== 4'd1) begin failures++; $display("FAIL simul_credits got=%0d exp=1", credits); end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL simul_overflow got=%b exp=0", overflow_err); end
        rsp_ready = 1'b1; req_valid = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_tid !== exp_tids[i]) begin
                failures++; $display("FAIL simul_drain_%0d got=%b/%0h exp=1/%0h", i, rsp_valid, rsp_tid, exp_tids[i]);
            end
            tick();
        end
        idle();
        checks++; if (rsp_valid !== 1'b0 || credits !== 4'd1) begin
            failures++; $display("FAIL simul_count got=%b/%0d exp=0/1", rsp_valid, credits);
        end
        do_reset();
    endtask

    task automatic test_overflow();
        issue_n(8);
        for (int i = 0; i < 8; i++) push_tid(9'h041 + 9'(i));
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL ovf_before got=%b exp=0", overflow_err); end
        push_tid(9'h049);
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_set got=%b exp=1", overflow_err); end
        tick(); tick();
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_hold got=%b exp=1", overflow_err); end
        rsp_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (rsp_valid !== 1'b1 || rsp_tid !== 9'h041 + 9'(i)) begin
                failures++; $display("FAIL ovf_drain_%0d got=%b/%0h exp=1/%0h", i, rsp_valid, rsp_tid, 9'h041 + 9'(i));
            end
            tick();
        end
        rsp_ready = 1'b0;
        checks++; if (rsp_valid !== 1'b0 || credits !== 4'd8) begin
            failures++; $display("FAIL ovf_dropped got=%b/%0d exp=0/8", rsp_valid, credits);
        end
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow_err); end
        do_reset();
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL ovf_cleared got=%b exp=0", overflow_err); end
    endtask

    task automatic test_reset_mid();
        issue_n(5);
        for (int i = 0; i < 3; i++) push_tid(9'h051 + 9'(i));
        checks++; if (credits !== 4'd3 || rsp_valid !== 1'b1) begin
            failures++; $display("FAIL mid_prep got=%0d/%b exp=3/1", credits, rsp_valid);
        end
        rst = 1'b1;
        tick();
        checks++; if (rsp_valid !== 1'b0 || credits !== 4'd8 || overflow_err !== 1'b0 || req_ready !== 1'b1) begin
            failures++; $display("FAIL mid_reset got=%b/%0d/%b/%b exp=0/8/0/1", rsp_valid, credits, overflow_err, req_ready);
        end
        rst = 1'b0;
        tick();
        checks++; if (rsp_valid !== 1'b0 || credits !== 4'd8) begin
            failures++; $display("FAIL mid_after got=%b/%0d exp=0/8", rsp_valid, credits);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_drain();
        test_count_one();
        test_full_simul();
        test_overflow();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
